// File: rtl/rxe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rxe_pkg
// Description : Shared CRC-32 constants and receive-checker state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package rxe_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hedb88320;
    localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
    localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;
    localparam logic [11:0] CNT_MAX       = 12'hfff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rxecrcchk_if.sv
`default_nettype none
// ============================================================================
// Module      : rxecrcchk_if
// Description : Nibble-stream bundle between the FCS checker and its neighbours.
// Revision    : 1.0  initial release
// ============================================================================
interface rxecrcchk_if;

    logic       i_en;
    logic       i_cancel;
    logic       i_v;
    logic [3:0] i_d;
    logic       o_v;
    logic [3:0] o_d;
    logic       o_err;

    modport master (
        output i_en, i_cancel, i_v, i_d,
        input  o_v, o_d, o_err
    );

    modport slave (
        input  i_en, i_cancel, i_v, i_d,
        output o_v, o_d, o_err
    );

endinterface
`default_nettype wire

// File: rtl/crc32_nibble.sv
`default_nettype none
// ============================================================================
// Module      : crc32_nibble
// Description : Combinational reflected CRC-32 step over one nibble, d[0] first.
// Revision    : 1.0  initial release
// ============================================================================
module crc32_nibble
    import rxe_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] crc,
    input  logic [3:0]  d,
    output logic [31:0] crc_next
);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc;
        for (int b = 0; b < 4; b++) begin
            if (w_c[0] ^ d[b]) begin
                w_c = (w_c >> 1) ^ POLY;
            end else begin
                w_c = w_c >> 1;
            end
        end
        crc_next = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/rxecrcchk.sv
`default_nettype none
// ============================================================================
// Module      : rxecrcchk
// Description : Receive-path Ethernet FCS checker on an MII nibble stream.
//               Define RXECRC_STRIP_EN to build the 8-nibble FCS strip line.
// Revision    : 1.0  initial release
// ============================================================================
module rxecrcchk
    import rxe_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    rxecrcchk_if.slave bus
);

    state_t      r_state;
    logic [31:0] r_crc;
    logic [11:0] r_cnt;
    logic        r_bypass;
    logic        r_ov;
    logic [3:0]  r_od;
    logic        r_err;

    logic [31:0] w_crc_in;
    logic [31:0] w_crc_next;
    logic [11:0] w_cnt_inc;
    logic        w_bad;

`ifdef RXECRC_STRIP_EN
    logic [3:0]  r_dly [0:7];
    logic [3:0]  r_occ;
`endif

    // A frame's first nibble folds into the init value, so one stepper serves both cases.
    assign w_crc_in  = (r_state == IDLE) ? CRC32_INIT : r_crc;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 12'd1;
    assign w_bad     = (r_crc != CRC32_RESIDUE) || (r_cnt < 12'd8) || r_cnt[0];

    crc32_nibble #(
        .POLY     (POLY)
    ) u_crc (
        .crc      (w_crc_in),
        .d        (bus.i_d),
        .crc_next (w_crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_crc    <= CRC32_INIT;
            r_cnt    <= 12'd0;
            r_bypass <= 1'b0;
            r_ov     <= 1'b0;
            r_od     <= 4'd0;
            r_err    <= 1'b0;
`ifdef RXECRC_STRIP_EN
            r_occ    <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_dly[i] <= 4'd0;
            end
`endif
        end else if (i_ce) begin
            if (bus.i_cancel && bus.i_v) begin
                r_state <= DRAIN;
                r_err   <= 1'b1;
                r_ov    <= 1'b0;
`ifdef RXECRC_STRIP_EN
                r_occ   <= 4'd0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ov <= 1'b0;
                        if (bus.i_v) begin
                            r_state  <= RUN;
                            r_crc    <= w_crc_next;
                            r_cnt    <= 12'd1;
                            r_err    <= 1'b0;
                            r_bypass <= ~bus.i_en;
`ifdef RXECRC_STRIP_EN
                            r_occ    <= 4'd1;
                            r_dly[0] <= bus.i_d;
                            if (!bus.i_en) begin
                                r_ov <= 1'b1;
                                r_od <= bus.i_d;
                            end
`else
                            r_ov     <= 1'b1;
                            r_od     <= bus.i_d;
`endif
                        end
                    end
                    RUN: begin
                        if (bus.i_v) begin
                            r_crc <= w_crc_next;
                            r_cnt <= w_cnt_inc;
`ifdef RXECRC_STRIP_EN
                            for (int i = 7; i > 0; i--) begin
                                r_dly[i] <= r_dly[i-1];
                            end
                            r_dly[0] <= bus.i_d;
                            if (r_occ != 4'd8) begin
                                r_occ <= r_occ + 4'd1;
                            end
                            if (r_bypass) begin
                                r_ov <= 1'b1;
                                r_od <= bus.i_d;
                            end else if (r_occ == 4'd8) begin
                                r_ov <= 1'b1;
                                r_od <= r_dly[7];
                            end else begin
                                r_ov <= 1'b0;
                            end
`else
                            r_ov  <= 1'b1;
                            r_od  <= bus.i_d;
`endif
                        end else begin
                            // Frame end: the eight retained nibbles are the FCS and are dropped.
                            r_state <= IDLE;
                            r_ov    <= 1'b0;
                            r_err   <= bus.i_cancel || (!r_bypass && w_bad);
                        end
                    end
                    DRAIN: begin
                        r_ov <= 1'b0;
                        if (!bus.i_v) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_ov    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_v   = r_ov;
    assign bus.o_d   = r_od;
    assign bus.o_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rxecrcchk.sv
`default_nettype none
// ============================================================================
// Module      : tb_rxecrcchk
// Description : Scoreboard bench for rxecrcchk; follows RXECRC_STRIP_EN if defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rxecrcchk;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    rxecrcchk_if bus ();

    rxecrcchk dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_d_q [$];
    logic       exp_err_q [$];

    logic [3:0] good_q [$];
    logic [3:0] tmp_q  [$];

    logic       s_ce, s_v, s_rst, prev_v;
    logic [3:0] e_d;
    logic       e_err;

    // One i_ce pulse per two clocks so registered outputs must hold across idle clocks.
    task automatic drive(input logic v, input logic [3:0] d, input logic cancel, input logic reset);
        @(negedge clk);
        ce           = 1'b1;
        bus.i_v      = v;
        bus.i_d      = d;
        bus.i_cancel = cancel;
        rst          = reset;
        @(negedge clk);
        ce           = 1'b0;
        rst          = 1'b0;
        bus.i_cancel = 1'b0;
    endtask

    task automatic push_out(input logic [3:0] frm [$], input int first, input int accepted, input logic en);
        int n;
        n = accepted;
`ifdef RXECRC_STRIP_EN
        if (en) n = (accepted > 8) ? accepted - 8 : 0;
`endif
        for (int i = 0; i < n; i++) exp_d_q.push_back(frm[first + i]);
    endtask

    task automatic send_frame(input logic [3:0] frm [$], input logic en, input int cancel_at, input logic exp_err);
        bus.i_en = en;
        push_out(frm, 0, (cancel_at >= 0) ? cancel_at : frm.size(), en);
        exp_err_q.push_back(exp_err);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], i == cancel_at, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every qualified output nibble and the error flag at each frame end.
    initial begin
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            s_ce  = ce;
            s_v   = bus.i_v;
            s_rst = rst;
            #1;
            if (s_ce && !s_rst) begin
                if (bus.o_v) begin
                    checks++;
                    if (exp_d_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: o_v=1 o_d=%h, required o_v=0", bus.o_d);
                    end else begin
                        e_d = exp_d_q.pop_front();
                        if (bus.o_d !== e_d) begin
                            errors++;
                            $display("FAIL out_data: o_d=%h required %h", bus.o_d, e_d);
                        end
                    end
                end
                if (prev_v && !s_v) begin
                    checks++;
                    if (exp_err_q.size() == 0) begin
                        errors++;
                        $display("FAIL err_unexpected_end: o_err=%b with no frame end expected", bus.o_err);
                    end else begin
                        e_err = exp_err_q.pop_front();
                        if (bus.o_err !== e_err) begin
                            errors++;
                            $display("FAIL frame_err: o_err=%b required %b", bus.o_err, e_err);
                        end
                    end
                end
            end
            if (s_rst) prev_v = 1'b0;
            else if (s_ce) prev_v = s_v;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        ce           = 1'b0;
        bus.i_en     = 1'b1;
        bus.i_cancel = 1'b0;
        bus.i_v      = 1'b0;
        bus.i_d      = 4'h0;
        good_q = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5, 4'h3,
                   4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3,
                   4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hf, 4'hb, 4'hc};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checks += 3;
        if (bus.o_v !== 1'b0)   begin errors++; $display("FAIL reset_o_v: got %b required 0", bus.o_v); end
        if (bus.o_d !== 4'h0)   begin errors++; $display("FAIL reset_o_d: got %h required 0", bus.o_d); end
        if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_o_err: got %b required 0", bus.o_err); end

        send_frame(good_q, 1'b1, -1, 1'b0);

        tmp_q = good_q;
        tmp_q[5] = tmp_q[5] ^ 4'h1;
        send_frame(tmp_q, 1'b1, -1, 1'b1);

        send_frame(good_q, 1'b1, 10, 1'b1);

        tmp_q = good_q[0:5];
        send_frame(tmp_q, 1'b1, -1, 1'b1);

        tmp_q = good_q;
        tmp_q.push_back(4'h0);
        send_frame(tmp_q, 1'b1, -1, 1'b1);

        send_frame(good_q, 1'b0, -1, 1'b0);

        // Reset lands on nibble 12; nibbles 13..25 then form an odd-length frame.
        bus.i_en = 1'b1;
        push_out(good_q, 0, 12, 1'b1);
        push_out(good_q, 13, 13, 1'b1);
        exp_err_q.push_back(1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, good_q[i], 1'b0, 1'b0);
        drive(1'b1, good_q[12], 1'b0, 1'b1);
        checks += 2;
        if (bus.o_v !== 1'b0)   begin errors++; $display("FAIL midreset_o_v: got %b required 0", bus.o_v); end
        if (bus.o_err !== 1'b0) begin errors++; $display("FAIL midreset_o_err: got %b required 0", bus.o_err); end
        for (int i = 13; i < 26; i++) drive(1'b1, good_q[i], 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);

        send_frame(good_q, 1'b1, -1, 1'b0);

        repeat (4) drive(1'b0, 4'h0, 1'b0, 1'b0);
        checks += 2;
        if (exp_d_q.size() != 0) begin
            errors++;
            $display("FAIL out_missing: %0d nibbles still pending, required 0", exp_d_q.size());
        end
        if (exp_err_q.size() != 0) begin
            errors++;
            $display("FAIL err_missing: %0d frame ends still pending, required 0", exp_err_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rxecrcchk.md
# rxecrcchk

Receive-path Ethernet FCS checker. It sits directly downstream of the preamble stripper and consumes its MII nibble stream, which carries destination MAC through FCS. It computes CRC-32 over each frame, optionally removes the trailing 4-byte FCS, and flags bad, short, odd-length or cancelled frames to the packet writer downstream.

## Interface
- `POLY`, default `32'hedb88320`: reflected CRC-32 polynomial.
- `i_clk`, input, 1: system clock.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_ce`, input, 1: nibble-rate clock enable. All state advances only when `i_ce` is high.
- `i_en`, input, 1: 1 = check (and strip); 0 = bypass.
- `i_cancel`, input, 1: abort the current frame.
- `i_v`, input, 1: input nibble valid. It stays high for the whole frame.
- `i_d`, input, 4: input nibble, low nibble of each byte first.
- `o_v`, output, 1: output nibble valid.
- `o_d`, output, 4: output nibble.
- `o_err`, output, 1: frame error, valid from end of frame.

## Operation
- **CRC update.** Applies per accepted nibble (`i_ce && i_v && !r_cancel`).
  - Bits are taken as `i_d[0]` first, then `i_d[1]`, `i_d[2]`, `i_d[3]`.
  - For each bit `b`: `fb = crc[0]^b`; `crc = (crc>>1) ^ (fb ? POLY : 0)`.
  - `crc` is loaded with `32'hffffffff` at frame start. There is no final XOR.
- **Good frame.** At end of frame the register must equal residue `32'hdebb20e3`.
- **Nibble counter.** 12 bits wide; saturates at 4095.
- **State machine (`IDLE`, `RUN`, `DRAIN`).**
  - `IDLE`: waits for `i_v`. The first valid nibble moves to `RUN`, re-initialises `crc`, empties the delay line, clears `o_err` and sets the counter to 1.
  - `RUN`: accepts nibbles. When `i_v` falls, move to `IDLE` and evaluate:
    - `o_err = (crc != residue) || (count < 8) || count[0]`.
  - `DRAIN` (cancel): entered on `i_cancel` in any state with `i_v` high.
    - Sets `o_err = 1`, forces `o_v` low and empties the delay line.
    - Ignores input until a `i_ce` cycle with `i_v` low, then returns to `IDLE`.
- **Delay line (strip mode).** 8-nibble shift register plus an occupancy count of 0–8.
  - An accepted nibble shifts in.
  - When occupancy was already 8, the oldest nibble is emitted: `o_v <= 1`, `o_d <= oldest`.
  - At end of frame the 8 retained nibbles are the FCS and are discarded, never emitted.
- **Bypass (`i_en` = 0, sampled at frame start and held for the frame).**
  - `o_v <= i_v`, `o_d <= i_d`.
  - CRC not checked; `o_err` held 0.
- **Simultaneous events.**
  - `i_cancel` outranks a frame end in the same cycle, so `o_err = 1`.
  - `i_reset` outranks everything.
- **`o_err` lifetime.** Holds its value until the next frame start or reset.

## Timing
- **Reset values:** `o_v = 0`, `o_d = 0`, `o_err = 0`; state `IDLE`; `crc = 32'hffffffff`; delay line empty; counter 0.
- **Strip latency:** nibble k appears on `o_d` one clock after the `i_ce` edge that accepts nibble k+8.
- **Bypass latency:** one clock.
- **`o_err` timing:** valid one clock after the first `i_ce` cycle with `i_v` low, at the same edge where `o_v` drops.
- **`o_v` between `i_ce` pulses:** outputs are registered, so `o_v` holds between `i_ce` pulses. The consumer qualifies with `i_ce`.
- **Gap required:** one `i_ce` cycle of `i_v` low between frames.
- **Back-to-back frames:** a frame starting on the next `i_ce` after a gap begins cleanly; the residue evaluation of the prior frame is already registered.

## Configuration
- `RXECRC_STRIP_EN` defined:
  - The delay line is built.
  - FCS nibbles are removed from the output.
  - Latency is 8 nibbles plus 1 clock.
- Undefined:
  - No delay line.
  - All nibbles, including the FCS, pass with 1-clock latency in check mode.
  - `o_err` is still computed identically.

## Structure
- **Shared package `rxe_pkg`:** `CRC32_POLY`, `CRC32_INIT` (`32'hffffffff`), `CRC32_RESIDUE` (`32'hdebb20e3`), state enum `{IDLE, RUN, DRAIN}`.
- **Sub-module `crc32_nibble`:** combinational; inputs `crc[31:0]` and `d[3:0]`, output next `crc`. It is reusable by the transmit FCS generator.

## Test plan
- **Good frame:** ASCII "123456789" as 18 nibbles (1,3,2,3,…,9,3) plus FCS nibbles 6,2,9,3,4,F,B,C, `i_en` = 1, strip on → exactly 18 `o_v` nibbles equal to the payload; `o_err` = 0.
- **Corrupted frame:** same frame with payload nibble 5 XOR 1 → 18 nibbles out; `o_err` = 1 after `i_v` falls.
- **Cancel:** `i_cancel` at nibble 10 → `o_v` low from the next clock; no further output until `i_v` idles; `o_err` = 1.
- **Short and odd frames:** 6-nibble frame → no `o_v`, `o_err` = 1. A 27-nibble frame (odd count) → `o_err` = 1.
- **Bypass:** `i_en` = 0 with the good frame → all 26 nibbles echoed with 1-clock latency; `o_err` = 0.
- **Reset mid-frame:** `i_reset` at nibble 12 → next clock `o_v` = 0, `o_err` = 0, state `IDLE`; `i_v` stays high through the rest of the frame, and with `i_v` still high at reset release the next `i_ce` is treated as a new frame start. The good frame then sent after a gap checks clean.
